// File: rtl/apb_requester_if.sv
// apb_if: APB5 bus between one requester and NUM_OF_SLAVES completers,
// including the per-signal odd-parity check bits.
interface apb_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_OF_SLAVES = 4
);
  localparam int AB = (ADDR_WIDTH + 7) / 8;
  localparam int DB = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0]    PADDR;
  logic [2:0]               PPROT;
  logic [NUM_OF_SLAVES-1:0] PSELx;
  logic                     PENABLE;
  logic                     PWRITE;
  logic [DATA_WIDTH-1:0]    PWDATA;
  logic [DB-1:0]            PSTRB;
  logic                     PWAKEUP;

  logic [AB-1:0]            PADDRCHK;
  logic                     PCTRLCHK;
  logic                     PSELxCHK;
  logic                     PENABLECHK;
  logic [DB-1:0]            PWDATACHK;
  logic                     PSTRBCHK;
  logic                     PWAKEUPCHK;

  logic                     PREADY;
  logic [DATA_WIDTH-1:0]    PRDATA;
  logic                     PSLVERR;
  logic                     PREADYCHK;
  logic [DB-1:0]            PRDATACHK;
  logic                     PSLVERRCHK;

  modport master (
    output PADDR, PPROT, PSELx, PENABLE,
    output PWRITE, PWDATA, PSTRB, PWAKEUP,
    output PADDRCHK, PCTRLCHK, PSELxCHK,
    output PENABLECHK, PWDATACHK, PSTRBCHK,
    output PWAKEUPCHK,
    input  PREADY, PRDATA, PSLVERR,
    input  PREADYCHK, PRDATACHK, PSLVERRCHK
  );

  modport slave (
    input  PADDR, PPROT, PSELx, PENABLE,
    input  PWRITE, PWDATA, PSTRB, PWAKEUP,
    input  PADDRCHK, PCTRLCHK, PSELxCHK,
    input  PENABLECHK, PWDATACHK, PSTRBCHK,
    input  PWAKEUPCHK,
    output PREADY, PRDATA, PSLVERR,
    output PREADYCHK, PRDATACHK, PSLVERRCHK
  );
endinterface

// File: rtl/apb_requester.sv
// apb_requester: cmd/rsp stream to APB5 SETUP/ACCESS transfers,
// with odd-parity generation, inbound checks and a wait-state timeout.
module apb_requester #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_OF_SLAVES  = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int SW = (NUM_OF_SLAVES > 1) ?
                     $clog2(NUM_OF_SLAVES) : 1
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  input  logic [SW-1:0]           cmd_sel,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_parerr,
  output logic                    rsp_timeout,
  apb_if.master                   apb
);
  localparam int AB = (ADDR_WIDTH + 7) / 8;
  localparam int DB = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TLAST =
    CW'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [SW:0] NSL = (SW+1)'(NUM_OF_SLAVES);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } state_t;

  state_t                   st;
  logic [CW-1:0]            wcnt;
  logic [ADDR_WIDTH-1:0]    paddr;
  logic [2:0]               pprot;
  logic [NUM_OF_SLAVES-1:0] psel;
  logic                     penable;
  logic                     pwrite;
  logic [DATA_WIDTH-1:0]    pwdata;
  logic [DB-1:0]            pstrb;
  logic                     pwakeup;

  logic                     in_range;
  logic [NUM_OF_SLAVES-1:0] sel_oh;
  logic                     sel_any;
  logic                     tmo_hit;
  logic                     done;
  logic                     rdy_perr;
  logic                     err_perr;
  logic                     rd_perr;
  logic [DB-1:0]            rd_odd;
  logic [AB-1:0]            addr_chk;
  logic [DB-1:0]            wdata_chk;

  assign in_range = {1'b0, cmd_sel} < NSL;
  assign sel_oh   = in_range ?
                    (NUM_OF_SLAVES'(1) << cmd_sel) : '0;
  assign sel_any  = |psel;
  assign tmo_hit  = TMO_EN && (wcnt == TLAST) && !apb.PREADY;
  assign done     = !sel_any || apb.PREADY || tmo_hit;

  // odd parity: a healthy signal+check pair has an odd popcount
  assign rdy_perr = ~(apb.PREADY ^ apb.PREADYCHK);
  assign err_perr = ~(apb.PSLVERR ^ apb.PSLVERRCHK);
  assign rd_perr  = ~&rd_odd;

  always_comb begin
    rd_odd    = apb.PRDATACHK;
    addr_chk  = '1;
    wdata_chk = '1;
    for (int i = 0; i < DATA_WIDTH; i++)
      rd_odd[i/8] = rd_odd[i/8] ^ apb.PRDATA[i];
    for (int i = 0; i < ADDR_WIDTH; i++)
      addr_chk[i/8] = addr_chk[i/8] ^ paddr[i];
    for (int i = 0; i < DATA_WIDTH; i++)
      wdata_chk[i/8] = wdata_chk[i/8] ^ pwdata[i];
  end

  assign apb.PADDR      = paddr;
  assign apb.PPROT      = pprot;
  assign apb.PSELx      = psel;
  assign apb.PENABLE    = penable;
  assign apb.PWRITE     = pwrite;
  assign apb.PWDATA     = pwdata;
  assign apb.PSTRB      = pstrb;
  assign apb.PWAKEUP    = pwakeup;
  assign apb.PADDRCHK   = addr_chk;
  assign apb.PWDATACHK  = wdata_chk;
  assign apb.PCTRLCHK   = ~^{pprot, pwrite};
  assign apb.PSELxCHK   = ~^psel;
  assign apb.PSTRBCHK   = ~^pstrb;
  assign apb.PENABLECHK = ~penable;
  assign apb.PWAKEUPCHK = ~pwakeup;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      st          <= IDLE;
      wcnt        <= '0;
      paddr       <= '0;
      pprot       <= '0;
      psel        <= '0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
      pwakeup     <= 1'b0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_parerr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      pwakeup <= cmd_valid || (st != IDLE);
      unique case (st)
        IDLE: if (cmd_valid) begin
          paddr       <= cmd_addr;
          pprot       <= cmd_prot;
          pwrite      <= cmd_write;
          pwdata      <= cmd_write ? cmd_wdata : '0;
          pstrb       <= cmd_write ? cmd_strb : '0;
          psel        <= sel_oh;
          cmd_ready   <= 1'b0;
          rsp_rdata   <= '0;
          rsp_slverr  <= 1'b0;
          rsp_parerr  <= 1'b0;
          rsp_timeout <= 1'b0;
          st          <= SETUP;
        end
        SETUP: begin
          penable <= 1'b1;
          wcnt    <= '0;
          st      <= ACCESS;
        end
        ACCESS: begin
          if (sel_any) begin
            wcnt       <= wcnt + 1'b1;
            rsp_parerr <= rsp_parerr | rdy_perr |
                          (apb.PREADY &
                           (err_perr | (~pwrite & rd_perr)));
          end
          if (done) begin
            psel        <= '0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_slverr  <= ~sel_any |
                           (apb.PREADY & apb.PSLVERR);
            rsp_timeout <= sel_any & ~apb.PREADY;
            rsp_rdata   <= (sel_any && apb.PREADY && !pwrite) ?
                           apb.PRDATA : '0;
            st          <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          st        <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
